// File: rtl/fwrisc_mem_arb_pkg.sv
// Shared types for the fwrisc single-port memory arbiter: FSM states,
// grant identifiers and the anti-starvation counter width.
package fwrisc_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GID_I = 1'b0,
    GID_D = 1'b1
  } gnt_id_e;

  // Wide enough for MAX_CONSEC up to 15
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] max_c
  );
    return (cnt >= max_c) ? max_c : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fwrisc_mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory bus.
// master = arbiter view, slave = requesters plus memory.
interface fwrisc_mem_arbiter_if;

  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;

  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic        dvalid;
  logic [31:0] drdata;
  logic        dready;

  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [3:0]  mwstb;
  logic        mwrite;
  logic        mvalid;
  logic [31:0] mrdata;
  logic        mready;

  modport master (
    input  iaddr, ivalid,
    output idata, iready,
    input  daddr, dwdata, dwstb, dwrite, dvalid,
    output drdata, dready,
    output maddr, mwdata, mwstb, mwrite, mvalid,
    input  mrdata, mready
  );

  modport slave (
    output iaddr, ivalid,
    input  idata, iready,
    output daddr, dwdata, dwstb, dwrite, dvalid,
    input  drdata, dready,
    input  maddr, mwdata, mwstb, mwrite, mvalid,
    output mrdata, mready
  );

endinterface

// File: rtl/fwrisc_mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// Kept standalone so property checkers can bind to the same decision logic.
module fwrisc_mem_arb_pick
  import fwrisc_mem_arb_pkg::*;
#(
  parameter bit PRIO_DATA  = 1'b1,
  parameter int MAX_CONSEC = 4
) (
  input  logic             ivalid,
  input  logic             dvalid,
  input  gnt_id_e          last_gnt,
  input  logic [CNT_W-1:0] consec_cnt,
  output logic             gnt_vld,
  output gnt_id_e          gnt_id
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CONSEC);

  always_comb begin
    gnt_vld = ivalid | dvalid;
    gnt_id  = GID_D;
    if (ivalid && dvalid) begin
      if (PRIO_DATA) begin
        // Data wins until fetch has watched MAX_CONSEC data grants go by
        gnt_id = (consec_cnt == MAX_C) ? GID_I : GID_D;
      end else begin
        gnt_id = (last_gnt == GID_D) ? GID_I : GID_D;
      end
    end else if (ivalid) begin
      gnt_id = GID_I;
    end
  end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Two-master arbiter sharing one memory bus between instruction fetch and
// load/store. Requests are registered onto m*; completion is combinational.
module fwrisc_mem_arbiter
  import fwrisc_mem_arb_pkg::*;
#(
  parameter bit PRIO_DATA  = 1'b1,
  parameter int MAX_CONSEC = 4
) (
  input logic                  clock,
  input logic                  reset,
  fwrisc_mem_arbiter_if.master bus
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CONSEC);

  arb_state_e       state_q, state_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      mwdata_q, mwdata_d;
  logic [3:0]       mwstb_q, mwstb_d;
  logic             mwrite_q, mwrite_d;
  logic             mvalid_q, mvalid_d;
  logic [CNT_W-1:0] consec_cnt_q, consec_cnt_d;
  gnt_id_e          last_gnt_q, last_gnt_d;

  logic    gnt_vld;
  gnt_id_e gnt_id;

  fwrisc_mem_arb_pick #(
    .PRIO_DATA  (PRIO_DATA),
    .MAX_CONSEC (MAX_CONSEC)
  ) u_pick (
    .ivalid     (bus.ivalid),
    .dvalid     (bus.dvalid),
    .last_gnt   (last_gnt_q),
    .consec_cnt (consec_cnt_q),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    maddr_d      = maddr_q;
    mwdata_d     = mwdata_q;
    mwstb_d      = mwstb_q;
    mwrite_d     = mwrite_q;
    mvalid_d     = mvalid_q;
    consec_cnt_d = consec_cnt_q;
    last_gnt_d   = last_gnt_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          mvalid_d   = 1'b1;
          last_gnt_d = gnt_id;
          if (gnt_id == GID_D) begin
            state_d  = GNT_D;
            maddr_d  = bus.daddr;
            mwdata_d = bus.dwdata;
            mwstb_d  = bus.dwstb;
            mwrite_d = bus.dwrite;
            // Only data grants that make fetch wait count towards starvation
            consec_cnt_d = bus.ivalid ? cnt_sat_inc(consec_cnt_q, MAX_C)
                                      : '0;
          end else begin
            state_d      = GNT_I;
            maddr_d      = bus.iaddr;
            mwdata_d     = '0;
            mwstb_d      = '0;
            mwrite_d     = 1'b0;
            consec_cnt_d = '0;
          end
        end
      end
      GNT_I, GNT_D: begin
        // Always return through IDLE so each transfer has a bubble
        if (bus.mready) begin
          state_d  = IDLE;
          mvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        mvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      maddr_q      <= '0;
      mwdata_q     <= '0;
      mwstb_q      <= '0;
      mwrite_q     <= 1'b0;
      mvalid_q     <= 1'b0;
      consec_cnt_q <= '0;
      last_gnt_q   <= GID_D;
    end else begin
      state_q      <= state_d;
      maddr_q      <= maddr_d;
      mwdata_q     <= mwdata_d;
      mwstb_q      <= mwstb_d;
      mwrite_q     <= mwrite_d;
      mvalid_q     <= mvalid_d;
      consec_cnt_q <= consec_cnt_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  assign bus.maddr  = maddr_q;
  assign bus.mwdata = mwdata_q;
  assign bus.mwstb  = mwstb_q;
  assign bus.mwrite = mwrite_q;
  assign bus.mvalid = mvalid_q;

  // Completion is the only combinational path through the block
  assign bus.iready = (state_q == GNT_I) && bus.mready;
  assign bus.dready = (state_q == GNT_D) && bus.mready;
  assign bus.idata  = bus.mrdata;
  assign bus.drdata = bus.mrdata;

endmodule
